matrix_op_sequencer: RTL

//  Command-level controller for the matrix op units (transpose, add, scalar-mul, multiply).

---
 rtl/matrix_op_sequencer_pkg.sv | 33 +++
 rtl/matrix_op_sequencer_mem_port_mux.sv | 42 ++++
 rtl/matrix_op_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_sequencer_pkg.sv
// Opcodes, response codes, field widths and sequencer state encoding shared by the
// matrix op sequencer and its memory port mux.
package matrix_op_sequencer_pkg;

   localparam int DIM_W = 5;
   localparam int CNT_W = 16;
   localparam int OP_W  = 3;

   localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD       = 3'd1;
   localparam logic [OP_W-1:0] OP_SCALAR    = 3'd2;
   localparam logic [OP_W-1:0] OP_MULT      = 3'd3;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_DIM     = 2'd1;
   localparam logic [1:0] ERR_OP      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_START   = 3'd2,
      ST_BUSY    = 3'd3,
      ST_RELEASE = 3'd4,
      ST_RESP    = 3'd5
   } seq_state_t;

   // A dimension is legal when it lies in 1..max_dim.
   function automatic logic dim_in_range(input logic [DIM_W-1:0] dim, input int max_dim);
      return (dim != 5'd0) && (int'(dim) <= max_dim);
   endfunction

endpackage

// File: rtl/matrix_op_sequencer_mem_port_mux.sv
// Combinational select of one op unit's memory port onto the shared BRAM port; no added
// latency, so each unit keeps its own read-then-capture timing.
module matrix_mem_port_mux #(
   parameter int ELEMENT_WIDTH = 16,
   parameter int ADDR_WIDTH    = 10,
   parameter int NUM_UNITS     = 4,
   parameter int SEL_W         = 2
) (
   input  logic [SEL_W-1:0]                   i_sel,
   input  logic                               i_sel_valid,
   input  logic [NUM_UNITS-1:0]               i_unit_rd_en,
   input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    i_unit_rd_addr,
   input  logic [NUM_UNITS-1:0]               i_unit_wr_en,
   input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    i_unit_wr_addr,
   input  logic [NUM_UNITS*ELEMENT_WIDTH-1:0] i_unit_wr_data,
   output logic                               o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]              o_mem_rd_addr,
   output logic                               o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]              o_mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0]           o_mem_wr_data
);

   // Without a valid selection the port is parked fully at zero.
   always_comb begin
      o_mem_rd_en   = 1'b0;
      o_mem_rd_addr = {ADDR_WIDTH{1'b0}};
      o_mem_wr_en   = 1'b0;
      o_mem_wr_addr = {ADDR_WIDTH{1'b0}};
      o_mem_wr_data = {ELEMENT_WIDTH{1'b0}};
      if (i_sel_valid) begin
         o_mem_rd_en   = i_unit_rd_en[i_sel];
         o_mem_rd_addr = i_unit_rd_addr[int'(i_sel)*ADDR_WIDTH +: ADDR_WIDTH];
         o_mem_wr_en   = i_unit_wr_en[i_sel];
         o_mem_wr_addr = i_unit_wr_addr[int'(i_sel)*ADDR_WIDTH +: ADDR_WIDTH];
         o_mem_wr_data = i_unit_wr_data[int'(i_sel)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end else begin
         o_mem_rd_en   = 1'b0;
         o_mem_wr_en   = 1'b0;
      end
   end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command-level controller for the matrix op units: validates one command at a time, runs
// the selected unit's start/done handshake, owns the shared BRAM port and reports status.
module matrix_op_sequencer
   import matrix_op_sequencer_pkg::*;
#(
   parameter int ELEMENT_WIDTH = 16,
   parameter int ADDR_WIDTH    = 10,
   parameter int NUM_UNITS     = 4,
   parameter int MAX_DIM       = 16,
   parameter int TIMEOUT_CYC   = 65535
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_cmd_valid,
   output logic                               o_cmd_ready,
   input  logic [2:0]                         i_cmd_op,
   input  logic [4:0]                         i_cmd_m,
   input  logic [4:0]                         i_cmd_n,
   input  logic [4:0]                         i_cmd_p,
   input  logic [ADDR_WIDTH-1:0]              i_cmd_addr_a,
   input  logic [ADDR_WIDTH-1:0]              i_cmd_addr_b,
   input  logic [ADDR_WIDTH-1:0]              i_cmd_addr_res,
   output logic                               o_rsp_valid,
   input  logic                               i_rsp_ready,
   output logic [1:0]                         o_rsp_err,
   output logic [15:0]                        o_rsp_cycles,
   output logic [NUM_UNITS-1:0]               o_unit_start,
   input  logic [NUM_UNITS-1:0]               i_unit_done,
   output logic [4:0]                         o_unit_m,
   output logic [4:0]                         o_unit_n,
   output logic [4:0]                         o_unit_p,
   output logic [ADDR_WIDTH-1:0]              o_unit_addr_a,
   output logic [ADDR_WIDTH-1:0]              o_unit_addr_b,
   output logic [ADDR_WIDTH-1:0]              o_unit_addr_res,
   input  logic [NUM_UNITS-1:0]               i_unit_rd_en,
   input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    i_unit_rd_addr,
   input  logic [NUM_UNITS-1:0]               i_unit_wr_en,
   input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    i_unit_wr_addr,
   input  logic [NUM_UNITS*ELEMENT_WIDTH-1:0] i_unit_wr_data,
   output logic                               o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]              o_mem_rd_addr,
   output logic                               o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]              o_mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0]           o_mem_wr_data
);

   localparam int                 SEL_W        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [NUM_UNITS-1:0] UNIT0      = NUM_UNITS'(1);

   seq_state_t             r_state, w_state_nxt;
   logic [OP_W-1:0]        r_op;
   logic [DIM_W-1:0]       r_m, r_n, r_p;
   logic [ADDR_WIDTH-1:0]  r_addr_a, r_addr_b, r_addr_res;
   logic [SEL_W-1:0]       r_sel, w_sel_nxt;
   logic                   r_sel_valid, w_sel_valid_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                   r_cmd_ready, w_cmd_ready_nxt;
   logic                   r_rsp_valid, w_rsp_valid_nxt;
   logic [1:0]             r_rsp_err, w_err_nxt, w_chk_err;
   logic [CNT_W-1:0]       r_rsp_cycles, w_rsp_cycles_nxt;
   logic [NUM_UNITS-1:0]   r_unit_start, w_start_nxt;
   logic                   w_accept, w_sel_done;

   assign w_accept   = i_cmd_valid & r_cmd_ready;
   assign w_sel_done = i_unit_done[r_sel];
   assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 16'd1;

   // Command validation on the latched fields; opcode errors outrank dimension errors.
   always_comb begin
      w_chk_err = ERR_OK;
      if (int'(r_op) >= NUM_UNITS) begin
         w_chk_err = ERR_OP;
      end else if (!dim_in_range(r_m, MAX_DIM) || !dim_in_range(r_n, MAX_DIM) ||
                   ((r_op == OP_MULT) && !dim_in_range(r_p, MAX_DIM))) begin
         w_chk_err = ERR_DIM;
      end else begin
         w_chk_err = ERR_OK;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; RELEASE holds until the unit has withdrawn done.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    w_state_nxt = w_accept ? ST_CHECK : ST_IDLE;
         ST_CHECK:   w_state_nxt = (w_chk_err != ERR_OK) ? ST_RESP : ST_START;
         ST_START:   w_state_nxt = ST_BUSY;
         ST_BUSY: begin
            if (w_sel_done) begin
               w_state_nxt = ST_RELEASE;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_RELEASE: w_state_nxt = w_sel_done ? ST_RELEASE : ST_RESP;
         ST_RESP:    w_state_nxt = i_rsp_ready ? ST_IDLE : ST_RESP;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, decoded from the next state.
   // The counter advances on every edge at which a start is being presented.
   always_comb begin
      w_sel_nxt = r_sel;
      w_cnt_nxt = r_cnt;
      w_err_nxt = r_rsp_err;
      case (r_state)
         ST_CHECK: begin
            w_sel_nxt = r_op[SEL_W-1:0];
            w_cnt_nxt = 16'd0;
            w_err_nxt = w_chk_err;
         end
         ST_START: w_cnt_nxt = w_cnt_inc;
         ST_BUSY: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_sel_done) begin
               w_err_nxt = ERR_OK;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_err_nxt = ERR_TIMEOUT;
            end else begin
               w_err_nxt = r_rsp_err;
            end
         end
         default: w_cnt_nxt = r_cnt;
      endcase
      w_cmd_ready_nxt  = (w_state_nxt == ST_IDLE) && !(|i_unit_done);
      w_rsp_valid_nxt  = (w_state_nxt == ST_RESP);
      w_sel_valid_nxt  = (w_state_nxt == ST_START) || (w_state_nxt == ST_BUSY) ||
                         (w_state_nxt == ST_RELEASE);
      w_start_nxt      = ((w_state_nxt == ST_START) || (w_state_nxt == ST_BUSY)) ?
                         (UNIT0 << w_sel_nxt) : {NUM_UNITS{1'b0}};
      w_rsp_cycles_nxt = (w_state_nxt == ST_RESP) ? w_cnt_nxt : r_rsp_cycles;
   end

   // Output and datapath registers; command fields are captured only on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_err    <= 2'd0;
         r_rsp_cycles <= 16'd0;
         r_unit_start <= {NUM_UNITS{1'b0}};
         r_sel        <= {SEL_W{1'b0}};
         r_sel_valid  <= 1'b0;
         r_cnt        <= 16'd0;
         r_op         <= 3'd0;
         r_m          <= 5'd0;
         r_n          <= 5'd0;
         r_p          <= 5'd0;
         r_addr_a     <= {ADDR_WIDTH{1'b0}};
         r_addr_b     <= {ADDR_WIDTH{1'b0}};
         r_addr_res   <= {ADDR_WIDTH{1'b0}};
      end else begin
         r_cmd_ready  <= w_cmd_ready_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_err    <= w_err_nxt;
         r_rsp_cycles <= w_rsp_cycles_nxt;
         r_unit_start <= w_start_nxt;
         r_sel        <= w_sel_nxt;
         r_sel_valid  <= w_sel_valid_nxt;
         r_cnt        <= w_cnt_nxt;
         if (w_accept) begin
            r_op       <= i_cmd_op;
            r_m        <= i_cmd_m;
            r_n        <= i_cmd_n;
            r_p        <= i_cmd_p;
            r_addr_a   <= i_cmd_addr_a;
            r_addr_b   <= i_cmd_addr_b;
            r_addr_res <= i_cmd_addr_res;
         end else begin
            r_op       <= r_op;
         end
      end
   end

   assign o_cmd_ready     = r_cmd_ready;
   assign o_rsp_valid     = r_rsp_valid;
   assign o_rsp_err       = r_rsp_err;
   assign o_rsp_cycles    = r_rsp_cycles;
   assign o_unit_start    = r_unit_start;
   assign o_unit_m        = r_m;
   assign o_unit_n        = r_n;
   assign o_unit_p        = r_p;
   assign o_unit_addr_a   = r_addr_a;
   assign o_unit_addr_b   = r_addr_b;
   assign o_unit_addr_res = r_addr_res;

   matrix_mem_port_mux #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NUM_UNITS     (NUM_UNITS),
      .SEL_W         (SEL_W)
   ) u_mem_mux (
      .i_sel          (r_sel),
      .i_sel_valid    (r_sel_valid),
      .i_unit_rd_en   (i_unit_rd_en),
      .i_unit_rd_addr (i_unit_rd_addr),
      .i_unit_wr_en   (i_unit_wr_en),
      .i_unit_wr_addr (i_unit_wr_addr),
      .i_unit_wr_data (i_unit_wr_data),
      .o_mem_rd_en    (o_mem_rd_en),
      .o_mem_rd_addr  (o_mem_rd_addr),
      .o_mem_wr_en    (o_mem_wr_en),
      .o_mem_wr_addr  (o_mem_wr_addr),
      .o_mem_wr_data  (o_mem_wr_data)
   );

endmodule
